// File: rtl/io_input_arbiter_if.sv
// Handshake bundle between the three input sources / CPU side and the
// shared input-path arbiter.
interface io_input_arbiter_if;
    logic       req_kbd;
    logic       req_ext;
    logic       req_tape;
    logic       cpu_ack;
    logic       cpu_mask;
    logic [2:0] grant;
    logic [1:0] src;
    logic       bl;
    logic       vv_strobe_n;
    logic       vv;
    logic       busy;
    logic       timeout;
    logic [7:0] overrun_cnt;

    // Source / CPU side: raises requests, acks and masks; observes the path.
    modport master (
        output req_kbd,
        output req_ext,
        output req_tape,
        output cpu_ack,
        output cpu_mask,
        input  grant,
        input  src,
        input  bl,
        input  vv_strobe_n,
        input  vv,
        input  busy,
        input  timeout,
        input  overrun_cnt
    );

    // Arbiter side.
    modport slave (
        input  req_kbd,
        input  req_ext,
        input  req_tape,
        input  cpu_ack,
        input  cpu_mask,
        output grant,
        output src,
        output bl,
        output vv_strobe_n,
        output vv,
        output busy,
        output timeout,
        output overrun_cnt
    );
endinterface

// File: rtl/io_input_arbiter.sv
// Round-robin arbiter and strobe sequencer for the shared peripheral input
// latch: settle, strobe, hold-for-ack (with timeout), release.
module io_input_arbiter #(
    parameter int unsigned SETTLE_CYCLES  = 2,
    parameter int unsigned STROBE_CYCLES  = 4,
    parameter int unsigned TIMEOUT_CYCLES = 65535
) (
    input logic               io_clk,
    input logic               init,
    io_input_arbiter_if.slave io
);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SETTLE,
        ST_STROBE,
        ST_HOLD,
        ST_RELEASE
    } state_e;

    localparam logic [15:0] SETTLE_LOAD  = 16'(SETTLE_CYCLES - 1);
    localparam logic [15:0] STROBE_LOAD  = 16'(STROBE_CYCLES - 1);
    localparam logic [15:0] TIMEOUT_LAST = 16'(TIMEOUT_CYCLES - 1);

    state_e      state_q, state_d;
    logic [2:0]  meta_q, meta_d;      // {tape, ext, kbd}
    logic [2:0]  sync_q, sync_d;
    logic [15:0] cnt_q, cnt_d;
    logic [1:0]  rr_ptr_q, rr_ptr_d;  // 0 kbd, 1 ext, 2 tape
    logic [1:0]  served_q, served_d;
    logic [2:0]  grant_q, grant_d;
    logic [1:0]  src_q, src_d;
    logic        bl_q, bl_d;
    logic        vv_strobe_n_q, vv_strobe_n_d;
    logic        vv_q, vv_d;
    logic        busy_q, busy_d;
    logic        timeout_q, timeout_d;
    logic [7:0]  overrun_q, overrun_d;
    logic [2:0]  pick;                // {valid, source index}

    // First requesting source at or after ptr, wrapping kbd -> ext -> tape.
    function automatic logic [2:0] rr_pick(input logic [2:0] reqs,
                                           input logic [1:0] ptr);
        logic [2:0] res;
        logic [2:0] sum;
        logic [1:0] idx;
        res = '0;
        for (int unsigned i = 0; i < 3; i++) begin
            sum = {1'b0, ptr} + 3'(i);
            idx = (sum >= 3'd3) ? 2'(sum - 3'd3) : 2'(sum);
            if (!res[2] && reqs[idx]) begin
                res = {1'b1, idx};
            end
        end
        return res;
    endfunction

    assign pick = rr_pick(sync_q, rr_ptr_q);

    always_ff @(posedge io_clk or posedge init) begin
        if (init) begin
            state_q       <= ST_IDLE;
            meta_q        <= '0;
            sync_q        <= '0;
            cnt_q         <= '0;
            rr_ptr_q      <= '0;
            served_q      <= '0;
            grant_q       <= '0;
            src_q         <= '0;
            bl_q          <= 1'b1;
            vv_strobe_n_q <= 1'b1;
            vv_q          <= 1'b0;
            busy_q        <= 1'b0;
            timeout_q     <= 1'b0;
            overrun_q     <= '0;
        end else begin
            state_q       <= state_d;
            meta_q        <= meta_d;
            sync_q        <= sync_d;
            cnt_q         <= cnt_d;
            rr_ptr_q      <= rr_ptr_d;
            served_q      <= served_d;
            grant_q       <= grant_d;
            src_q         <= src_d;
            bl_q          <= bl_d;
            vv_strobe_n_q <= vv_strobe_n_d;
            vv_q          <= vv_d;
            busy_q        <= busy_d;
            timeout_q     <= timeout_d;
            overrun_q     <= overrun_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        meta_d  = {io.req_tape, io.req_ext, io.req_kbd};
        sync_d  = meta_q;
        unique case (state_q)
            ST_IDLE: begin
                if (!io.cpu_mask && pick[2]) begin
                    state_d = ST_SETTLE;
                    cnt_d   = SETTLE_LOAD;
                end
            end
            ST_SETTLE: begin
                if (cnt_q == '0) begin
                    state_d = ST_STROBE;
                    cnt_d   = STROBE_LOAD;
                end else begin
                    cnt_d = cnt_q - 16'd1;
                end
            end
            ST_STROBE: begin
                if (cnt_q == '0) begin
                    state_d = ST_HOLD;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q - 16'd1;
                end
            end
            ST_HOLD: begin
                // Ack takes priority over expiry on the same edge.
                if (io.cpu_ack || cnt_q == TIMEOUT_LAST) begin
                    state_d = ST_RELEASE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            ST_RELEASE: begin
                if (!sync_q[served_q]) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    always_comb begin
        grant_d       = grant_q;
        src_d         = src_q;
        bl_d          = bl_q;
        served_d      = served_q;
        rr_ptr_d      = rr_ptr_q;
        overrun_d     = overrun_q;
        timeout_d     = 1'b0;
        vv_strobe_n_d = (state_d != ST_STROBE);
        vv_d          = (state_d == ST_HOLD);
        busy_d        = (state_d != ST_IDLE);

        if (state_q == ST_IDLE && state_d == ST_SETTLE) begin
            served_d = pick[1:0];
            grant_d  = 3'b001 << pick[1:0];
            src_d    = pick[1:0] + 2'd1;
            bl_d     = (pick[1:0] != 2'd0);
        end

        if (state_q == ST_HOLD && state_d == ST_RELEASE) begin
            grant_d  = '0;
            src_d    = '0;
            bl_d     = 1'b1;
            rr_ptr_d = (served_q == 2'd2) ? 2'd0 : served_q + 2'd1;
            if (!io.cpu_ack) begin
                timeout_d = 1'b1;
                if (overrun_q != '1) begin
                    overrun_d = overrun_q + 8'd1;
                end
            end
        end
    end

    assign io.grant       = grant_q;
    assign io.src         = src_q;
    assign io.bl          = bl_q;
    assign io.vv_strobe_n = vv_strobe_n_q;
    assign io.vv          = vv_q;
    assign io.busy        = busy_q;
    assign io.timeout     = timeout_q;
    assign io.overrun_cnt = overrun_q;

    a_grant_onehot: assert property (@(posedge io_clk) disable iff (init)
        $onehot0(grant_q));
    a_no_vv_during_strobe: assert property (@(posedge io_clk) disable iff (init)
        !(vv_q && !vv_strobe_n_q));

endmodule

// File: tb/tb_io_input_arbiter.sv
// Self-checking bench for io_input_arbiter: directed scenarios plus randomized
// transactions checked against a timeline/round-robin reference model.
module tb_io_input_arbiter;

    localparam int S  = 2;
    localparam int ST = 4;
    localparam int T  = 16;

    logic io_clk;
    logic init;
    int   total;
    int   bad;
    int   rr_m;
    int   ov_m;

    io_input_arbiter_if bus();

    io_input_arbiter #(
        .SETTLE_CYCLES (S),
        .STROBE_CYCLES (ST),
        .TIMEOUT_CYCLES(T)
    ) dut (
        .io_clk(io_clk),
        .init  (init),
        .io    (bus)
    );

    initial begin
        io_clk = 1'b0;
        forever #5 io_clk = ~io_clk;
    end

    initial begin
        #1500000;
        $display("FAIL watchdog: got=still running exp=finished");
        $fatal(1, "watchdog expired");
    end

    function automatic int pick(input logic [2:0] m, input int rr);
        for (int i = 0; i < 3; i++) begin
            if (m[(rr + i) % 3]) return (rr + i) % 3;
        end
        return -1;
    endfunction

    task automatic tick();
        @(posedge io_clk);
        #1;
    endtask

    task automatic do_reset();
        init = 1'b1;
        {bus.req_tape, bus.req_ext, bus.req_kbd} = 3'b000;
        bus.cpu_ack  = 1'b0;
        bus.cpu_mask = 1'b0;
        tick();
        tick();
        init = 1'b0;
        rr_m = 0;
        ov_m = 0;
    endtask

    task automatic test_reset();
        #2 init = 1'b1;
        #1;
        total++; if (bus.grant !== 3'b000) begin bad++; $display("FAIL rst_grant got=%b exp=000", bus.grant); end
        total++; if (bus.src !== 2'd0) begin bad++; $display("FAIL rst_src got=%0d exp=0", bus.src); end
        total++; if (bus.bl !== 1'b1) begin bad++; $display("FAIL rst_bl got=%b exp=1", bus.bl); end
        total++; if (bus.vv_strobe_n !== 1'b1) begin bad++; $display("FAIL rst_strobe got=%b exp=1", bus.vv_strobe_n); end
        total++; if (bus.vv !== 1'b0) begin bad++; $display("FAIL rst_vv got=%b exp=0", bus.vv); end
        total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL rst_busy got=%b exp=0", bus.busy); end
        total++; if (bus.timeout !== 1'b0) begin bad++; $display("FAIL rst_timeout got=%b exp=0", bus.timeout); end
        total++; if (bus.overrun_cnt !== 8'd0) begin bad++; $display("FAIL rst_overrun got=%0d exp=0", bus.overrun_cnt); end
        tick();
        tick();
        init = 1'b0;
    endtask

    task automatic test_single_kbd();
        do_reset();
        bus.req_kbd = 1'b1;
        for (int e = 0; e <= 17; e++) begin
            tick();
            if (e == 2) begin
                total++; if (bus.grant !== 3'b001) begin bad++; $display("FAIL kbd_grant got=%b exp=001", bus.grant); end
                total++; if (bus.bl !== 1'b0) begin bad++; $display("FAIL kbd_bl got=%b exp=0", bus.bl); end
                total++; if (bus.src !== 2'd1) begin bad++; $display("FAIL kbd_src got=%0d exp=1", bus.src); end
            end
            if (e == 12) begin
                total++; if (bus.grant !== 3'b000) begin bad++; $display("FAIL kbd_grant_rel got=%b exp=000", bus.grant); end
                total++; if (bus.bl !== 1'b1) begin bad++; $display("FAIL kbd_bl_rel got=%b exp=1", bus.bl); end
            end
            total++; if (bus.vv_strobe_n !== !(e >= 4 && e <= 7)) begin bad++; $display("FAIL kbd_strobe e=%0d got=%b exp=%b", e, bus.vv_strobe_n, !(e >= 4 && e <= 7)); end
            total++; if (bus.vv !== (e >= 8 && e <= 11)) begin bad++; $display("FAIL kbd_vv e=%0d got=%b exp=%b", e, bus.vv, (e >= 8 && e <= 11)); end
            total++; if (bus.busy !== (e >= 2 && e <= 15)) begin bad++; $display("FAIL kbd_busy e=%0d got=%b exp=%b", e, bus.busy, (e >= 2 && e <= 15)); end
            total++; if (bus.timeout !== 1'b0) begin bad++; $display("FAIL kbd_timeout e=%0d got=%b exp=0", e, bus.timeout); end
            bus.cpu_ack = (e == 11);
            if (e == 13) bus.req_kbd = 1'b0;
        end
        total++; if (bus.overrun_cnt !== 8'd0) begin bad++; $display("FAIL kbd_overrun got=%0d exp=0", bus.overrun_cnt); end
        rr_m = 1;
    endtask

    task automatic test_round_robin();
        logic [2:0] avail;
        int         idx;
        int         last;
        do_reset();
        {bus.req_tape, bus.req_ext, bus.req_kbd} = 3'b111;
        last = -1;
        for (int n = 0; n < 4; n++) begin
            avail = 3'b111;
            if (last >= 0) avail[last] = 1'b0;
            idx = pick(avail, rr_m);
            for (int w = 0; w < 20 && bus.busy !== 1'b1; w++) tick();
            total++; if (bus.grant !== 3'(1 << idx)) begin bad++; $display("FAIL rr_grant n=%0d got=%b exp=%b", n, bus.grant, 3'(1 << idx)); end
            total++; if (bus.bl !== (idx != 0)) begin bad++; $display("FAIL rr_bl n=%0d got=%b exp=%b", n, bus.bl, (idx != 0)); end
            for (int w = 0; w < 20 && bus.vv !== 1'b1; w++) tick();
            total++; if (bus.vv !== 1'b1) begin bad++; $display("FAIL rr_vv_rise n=%0d got=%b exp=1", n, bus.vv); end
            bus.cpu_ack = 1'b1;
            tick();
            bus.cpu_ack = 1'b0;
            total++; if (bus.vv !== 1'b0) begin bad++; $display("FAIL rr_vv_fall n=%0d got=%b exp=0", n, bus.vv); end
            case (idx)
                0: bus.req_kbd  = 1'b0;
                1: bus.req_ext  = 1'b0;
                default: bus.req_tape = 1'b0;
            endcase
            for (int w = 0; w < 20 && bus.busy !== 1'b0; w++) tick();
            total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL rr_release n=%0d got=%b exp=0", n, bus.busy); end
            {bus.req_tape, bus.req_ext, bus.req_kbd} = 3'b111;
            rr_m = (idx + 1) % 3;
            last = idx;
        end
        {bus.req_tape, bus.req_ext, bus.req_kbd} = 3'b000;
        for (int w = 0; w < 60 && !(bus.busy === 1'b0 && bus.grant === 3'b000); w++) begin
            if (bus.vv === 1'b1) bus.cpu_ack = 1'b1;
            tick();
            bus.cpu_ack = 1'b0;
        end
    endtask

    task automatic test_timeout();
        do_reset();
        for (int n = 1; n <= 260; n++) begin
            bus.req_ext = 1'b1;
            for (int w = 0; w < 20 && bus.vv !== 1'b1; w++) tick();
            total++; if (bus.vv !== 1'b1) begin bad++; $display("FAIL to_vv_rise n=%0d got=%b exp=1", n, bus.vv); end
            for (int j = 1; j <= T; j++) begin
                tick();
                total++; if (bus.timeout !== (j == T)) begin bad++; $display("FAIL to_pulse n=%0d j=%0d got=%b exp=%b", n, j, bus.timeout, (j == T)); end
                total++; if (bus.vv !== (j < T)) begin bad++; $display("FAIL to_vv n=%0d j=%0d got=%b exp=%b", n, j, bus.vv, (j < T)); end
            end
            if (ov_m < 255) ov_m++;
            total++; if (bus.overrun_cnt !== 8'(ov_m)) begin bad++; $display("FAIL to_overrun n=%0d got=%0d exp=%0d", n, bus.overrun_cnt, ov_m); end
            total++; if (bus.grant !== 3'b000) begin bad++; $display("FAIL to_grant n=%0d got=%b exp=000", n, bus.grant); end
            bus.req_ext = 1'b0;
            tick();
            total++; if (bus.timeout !== 1'b0) begin bad++; $display("FAIL to_pulse_end n=%0d got=%b exp=0", n, bus.timeout); end
            for (int w = 0; w < 10 && bus.busy !== 1'b0; w++) tick();
            total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL to_release n=%0d got=%b exp=0", n, bus.busy); end
        end
        total++; if (bus.overrun_cnt !== 8'd255) begin bad++; $display("FAIL to_saturate got=%0d exp=255", bus.overrun_cnt); end
    endtask

    task automatic test_collision();
        do_reset();
        bus.req_kbd = 1'b1;
        for (int w = 0; w < 20 && bus.vv !== 1'b1; w++) tick();
        total++; if (bus.vv !== 1'b1) begin bad++; $display("FAIL col_vv_rise got=%b exp=1", bus.vv); end
        for (int j = 1; j <= T; j++) begin
            bus.cpu_ack = (j == T);
            tick();
            bus.cpu_ack = 1'b0;
            total++; if (bus.vv !== (j < T)) begin bad++; $display("FAIL col_vv j=%0d got=%b exp=%b", j, bus.vv, (j < T)); end
            total++; if (bus.timeout !== 1'b0) begin bad++; $display("FAIL col_timeout j=%0d got=%b exp=0", j, bus.timeout); end
        end
        total++; if (bus.grant !== 3'b000) begin bad++; $display("FAIL col_grant got=%b exp=000", bus.grant); end
        tick();
        total++; if (bus.timeout !== 1'b0) begin bad++; $display("FAIL col_timeout_after got=%b exp=0", bus.timeout); end
        total++; if (bus.overrun_cnt !== 8'(ov_m)) begin bad++; $display("FAIL col_overrun got=%0d exp=%0d", bus.overrun_cnt, ov_m); end
        bus.req_kbd = 1'b0;
        for (int w = 0; w < 10 && bus.busy !== 1'b0; w++) tick();
        total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL col_release got=%b exp=0", bus.busy); end
    endtask

    task automatic test_reset_mid_strobe();
        do_reset();
        bus.req_kbd = 1'b1;
        for (int w = 0; w < 20 && bus.vv_strobe_n !== 1'b0; w++) tick();
        total++; if (bus.vv_strobe_n !== 1'b0) begin bad++; $display("FAIL rms_strobe_seen got=%b exp=0", bus.vv_strobe_n); end
        #2 init = 1'b1;
        #1;
        total++; if (bus.vv_strobe_n !== 1'b1) begin bad++; $display("FAIL rms_strobe got=%b exp=1", bus.vv_strobe_n); end
        total++; if (bus.grant !== 3'b000) begin bad++; $display("FAIL rms_grant got=%b exp=000", bus.grant); end
        total++; if (bus.bl !== 1'b1) begin bad++; $display("FAIL rms_bl got=%b exp=1", bus.bl); end
        total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL rms_busy got=%b exp=0", bus.busy); end
        tick();
        init = 1'b0;
        rr_m = 0;
        ov_m = 0;
        tick();
        tick();
        total++; if (bus.grant !== 3'b000) begin bad++; $display("FAIL rms_early_grant got=%b exp=000", bus.grant); end
        tick();
        total++; if (bus.grant !== 3'b001) begin bad++; $display("FAIL rms_regrant got=%b exp=001", bus.grant); end
        total++; if (bus.overrun_cnt !== 8'd0) begin bad++; $display("FAIL rms_overrun got=%0d exp=0", bus.overrun_cnt); end
        for (int w = 0; w < 20 && bus.vv !== 1'b1; w++) tick();
        bus.cpu_ack = 1'b1;
        tick();
        bus.cpu_ack = 1'b0;
        bus.req_kbd = 1'b0;
        for (int w = 0; w < 10 && bus.busy !== 1'b0; w++) tick();
        total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL rms_release got=%b exp=0", bus.busy); end
    endtask

    task automatic test_mask();
        do_reset();
        bus.cpu_mask = 1'b1;
        bus.req_tape = 1'b1;
        for (int k = 0; k < 8; k++) begin
            tick();
            total++; if (bus.grant !== 3'b000) begin bad++; $display("FAIL mask_grant k=%0d got=%b exp=000", k, bus.grant); end
            total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL mask_busy k=%0d got=%b exp=0", k, bus.busy); end
        end
        bus.cpu_mask = 1'b0;
        tick();
        total++; if (bus.grant !== 3'b100) begin bad++; $display("FAIL unmask_grant got=%b exp=100", bus.grant); end
        total++; if (bus.src !== 2'd3) begin bad++; $display("FAIL unmask_src got=%0d exp=3", bus.src); end
        total++; if (bus.bl !== 1'b1) begin bad++; $display("FAIL unmask_bl got=%b exp=1", bus.bl); end
        bus.req_tape = 1'b0;
        for (int j = 1; j <= S + ST; j++) begin
            tick();
            total++; if (bus.vv !== (j == S + ST)) begin bad++; $display("FAIL drop_vv j=%0d got=%b exp=%b", j, bus.vv, (j == S + ST)); end
            total++; if (bus.vv_strobe_n !== !(j >= S && j < S + ST)) begin bad++; $display("FAIL drop_strobe j=%0d got=%b exp=%b", j, bus.vv_strobe_n, !(j >= S && j < S + ST)); end
        end
        bus.cpu_ack = 1'b1;
        tick();
        bus.cpu_ack = 1'b0;
        total++; if (bus.vv !== 1'b0) begin bad++; $display("FAIL drop_vv_fall got=%b exp=0", bus.vv); end
        for (int w = 0; w < 10 && bus.busy !== 1'b0; w++) tick();
        total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL drop_release got=%b exp=0", bus.busy); end
    endtask

    // Each iteration: random request set, random ack point (some past expiry).
    task automatic test_random();
        do_reset();
        for (int it = 0; it < 40; it++) begin
            logic [2:0] m;
            logic [2:0] eg;
            logic [1:0] es;
            logic       in_txn;
            int idx, k, v, fin, eov;
            bit timed;
            m     = 3'($urandom_range(1, 7));
            idx   = pick(m, rr_m);
            v     = 2 + S + ST;
            k     = $urandom_range(1, T + 4);
            timed = (k > T);
            fin   = timed ? v + T : v + k;
            {bus.req_tape, bus.req_ext, bus.req_kbd} = m;
            for (int e = 0; e <= fin + 5; e++) begin
                tick();
                in_txn = (e >= 2 && e < fin);
                eg  = in_txn ? 3'(1 << idx) : 3'b000;
                es  = in_txn ? 2'(idx + 1) : 2'd0;
                eov = (timed && e >= fin && ov_m < 255) ? ov_m + 1 : ov_m;
                total++; if (bus.grant !== eg) begin bad++; $display("FAIL rnd_grant it=%0d e=%0d got=%b exp=%b", it, e, bus.grant, eg); end
                total++; if (bus.src !== es) begin bad++; $display("FAIL rnd_src it=%0d e=%0d got=%0d exp=%0d", it, e, bus.src, es); end
                total++; if (bus.bl !== (in_txn ? (idx != 0) : 1'b1)) begin bad++; $display("FAIL rnd_bl it=%0d e=%0d got=%b", it, e, bus.bl); end
                total++; if (bus.vv_strobe_n !== !(e >= 2 + S && e < v)) begin bad++; $display("FAIL rnd_strobe it=%0d e=%0d got=%b exp=%b", it, e, bus.vv_strobe_n, !(e >= 2 + S && e < v)); end
                total++; if (bus.vv !== (e >= v && e < fin)) begin bad++; $display("FAIL rnd_vv it=%0d e=%0d got=%b exp=%b", it, e, bus.vv, (e >= v && e < fin)); end
                total++; if (bus.timeout !== (timed && e == fin)) begin bad++; $display("FAIL rnd_timeout it=%0d e=%0d got=%b exp=%b", it, e, bus.timeout, (timed && e == fin)); end
                total++; if (bus.busy !== (e >= 2 && e < fin + 4)) begin bad++; $display("FAIL rnd_busy it=%0d e=%0d got=%b exp=%b", it, e, bus.busy, (e >= 2 && e < fin + 4)); end
                total++; if (bus.overrun_cnt !== 8'(eov)) begin bad++; $display("FAIL rnd_overrun it=%0d e=%0d got=%0d exp=%0d", it, e, bus.overrun_cnt, eov); end
                bus.cpu_ack = (e + 1 == v + k);
                if (e == fin + 1) {bus.req_tape, bus.req_ext, bus.req_kbd} = 3'b000;
            end
            bus.cpu_ack = 1'b0;
            rr_m = (idx + 1) % 3;
            if (timed && ov_m < 255) ov_m++;
        end
    endtask

    initial begin
        total        = 0;
        bad          = 0;
        rr_m         = 0;
        ov_m         = 0;
        init         = 1'b0;
        bus.req_kbd  = 1'b0;
        bus.req_ext  = 1'b0;
        bus.req_tape = 1'b0;
        bus.cpu_ack  = 1'b0;
        bus.cpu_mask = 1'b0;
        test_reset();
        test_single_kbd();
        test_round_robin();
        test_timeout();
        test_collision();
        test_reset_mid_strobe();
        test_mask();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
